uart_mmio_periph: RTL and testbench
===================================

# uart_mmio_periph

Memory-mapped UART peripheral that responds to the pipeline CPU's MEM-stage data-bus accesses (Address/Write_data/MemRead/MemWrite) for the UART_TXD, UART_RXD and UART_CON words. It contains:
- an 8N1 transmitter
- a mid-bit-sampling receiver
- status/interrupt logic

The top level muxes `Mem_data` from this block or DataMem using `hit`.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per UART bit (≥4).
- `BASE_ADDR`, 32'h40000018: address of UART_TXD. UART_RXD is at +4 and UART_CON at +8.
- `clk`  in  1  system clock (one clock). All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Address`  in  32  byte address from the EX/MEM register.
- `Write_data`  in  32  store data.
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `Mem_data`  out  32  read data. Combinational; zero-extended.
- `hit`  out  1  combinational. 1 when `Address` equals one of the three mapped words.
- `uart_rx`  in  1  serial input. Asynchronous; idle high.
- `uart_tx`  out  1  serial output. Registered; idle high.
- `irq`  out  1  interrupt request.

## Operation
- **Register map:**
  - TXD (BASE): R/W `[7:0]`.
  - RXD (BASE+4): R-only `[7:0]`.
  - CON (BASE+8) `[4:0]`:
    - bit 0 TX irq enable (R/W)
    - bit 1 RX irq enable (R/W)
    - bit 2 rx_valid (RO)
    - bit 3 tx_done (RO)
    - bit 4 tx_busy (RO)
- **Reset values:** TXD=0, RXD=0, CON=0, `uart_tx`=1, `irq`=0, both FSMs idle.
- **Address decode:** only exact word addresses decode. `Address[1:0]`≠0 or an unmapped address gives `hit`=0 and `Mem_data`=0.
- **Reads:** unmapped bits read 0.
- **Store to TXD:**
  - tx_busy=0: loads TXD and starts a frame.
  - tx_busy=1: store ignored, TXD unchanged.
- **Store to CON:** updates bits `[1:0]` only.
- **Load from CON:** clears bits 2 and 3 at that edge (read-to-clear). Loads of TXD and RXD have no side effect.
- **TX FSM, IDLE→START→DATA→STOP→IDLE:**
  - Each state lasts CLKS_PER_BIT cycles (DATA lasts 8×).
  - Data is sent LSB first.
  - tx_busy=1 in all non-IDLE states.
  - On leaving STOP: tx_busy←0 and tx_done←1.
- **RX synchronisation:** `uart_rx` passes through a 2-FF synchroniser.
- **RX FSM, IDLE→START→DATA→STOP→IDLE:**
  - IDLE: a synchronised 1→0 transition enters START.
  - START: waits CLKS_PER_BIT/2 (floor), then samples. If high, it was a glitch: return to IDLE. Otherwise go to DATA.
  - DATA: samples 8 bits, LSB first, each CLKS_PER_BIT apart.
  - STOP: samples after CLKS_PER_BIT.
    - Stop=1: RXD←byte, rx_valid←1.
    - Stop=0: framing error. Byte discarded, no status change.
  - Then returns to IDLE.
- **Overrun:** a new byte overwrites RXD; rx_valid stays 1.
- **irq** = (CON[0]&tx_done) | (CON[1]&rx_valid), decoded from registered state.

## Timing
- Store to TXD at edge k:
  - tx_busy=1 after edge k.
  - `uart_tx`=0 (start bit) after edge k+1.
  - Frame is 10×CLKS_PER_BIT cycles.
  - tx_done=1 and tx_busy=0 after edge k+1+10×CLKS_PER_BIT.
- Read data has zero cycles of latency: valid in the same cycle as the address.
- RX byte becomes visible 2 cycles (synchroniser) plus 9.5×CLKS_PER_BIT after the falling edge of the start bit, ±1 cycle.
- **Simultaneous events:**
  - A set of rx_valid or tx_done on the same edge as a CON read-clear: the set wins, and the cleared flag stays 1.
  - A store to TXD on the same edge tx_busy falls: ignored, because busy is sampled before the edge.
- **Reset mid-frame:** immediate abort. `uart_tx`→1 asynchronously, status and FSMs cleared, partial RX byte lost.
- `MemRead` and `MemWrite` both high: the write is applied. The CON read-clear also applies if the address is CON.

## Test plan
1. CLKS_PER_BIT=8, reset low then high. Then check `uart_tx`=1, `irq`=0, a CON read gives 0, and address BASE+12 gives `hit`=0 with `Mem_data`=0.
2. Store 0xA5 to TXD:
   - `uart_tx` frame is 0, 1,0,1,0,0,1,0,1, 1; each bit lasts 8 cycles.
   - CON reads 0x10 during the frame and 0x08 after it.
   - A second CON read gives 0.
3. Enable CON=0x2. Drive a 0x3C frame on `uart_rx`. Then:
   - RXD reads 0x3C and `irq`=1.
   - Reading CON returns 0x06, then `irq`=0.
4. Negative cases on `uart_rx`:
   - A 3-cycle low glitch leaves RX idle with no rx_valid.
   - A frame with stop bit=0 leaves RXD unchanged and rx_valid=0.
5. During a TX frame, store 0x55 to TXD. Afterwards TXD still reads 0xA5 and only one frame is sent.
6. Overrun: receive two bytes with no read; RXD holds the second byte. Then:
   - Arrange an RX completion on the same edge as a CON read; rx_valid remains 1.
   - Assert reset mid-TX; `uart_tx` goes to 1 immediately.

Source files
------------

// File: rtl/uart_mmio_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON words on the MEM-stage data bus,
// with a registered transmitter, mid-bit receiver and level irq.
module uart_mmio_periph #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Mem_data,
  output logic        hit,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;

  state_e          tx_state_q, tx_state_d;
  state_e          rx_state_q, rx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      txd_q, txd_d;
  logic [7:0]      rxd_q, rxd_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [1:0]      ie_q, ie_d;
  logic            tx_done_q, tx_done_d;
  logic            rx_valid_q, rx_valid_d;
  logic            uart_tx_q, uart_tx_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic            sel_txd, sel_rxd, sel_con;
  logic            con_rd, con_wr, txd_wr;
  logic            tx_busy, tx_set, rx_set;
  logic            unused_wdata;

  assign unused_wdata = ^Write_data[31:8];

  assign sel_txd = (Address == BASE_ADDR);
  assign sel_rxd = (Address == BASE_ADDR + 32'd4);
  assign sel_con = (Address == BASE_ADDR + 32'd8);
  assign hit     = sel_txd | sel_rxd | sel_con;

  assign tx_busy = (tx_state_q != S_IDLE);
  assign con_rd  = MemRead & sel_con;
  assign con_wr  = MemWrite & sel_con;
  assign txd_wr  = MemWrite & sel_txd & ~tx_busy;

  always_comb begin
    Mem_data = '0;
    unique case (1'b1)
      sel_txd: Mem_data = {24'd0, txd_q};
      sel_rxd: Mem_data = {24'd0, rxd_q};
      sel_con: Mem_data = {27'd0, tx_busy, tx_done_q,
                           rx_valid_q, ie_q};
      default: Mem_data = '0;
    endcase
  end

  // STOP holds one extra cycle so busy drops as the line's stop bit ends
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
    tx_set     = 1'b0;
    uart_tx_d  = 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (txd_wr) begin
          txd_d      = Write_data[7:0];
          tx_state_d = S_START;
        end
      end
      S_START: begin
        uart_tx_d = 1'b0;
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        uart_tx_d = txd_q[tx_bit_q];
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == STOP_END) begin
          tx_cnt_d   = '0;
          tx_set     = 1'b1;
          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rxd_d      = rxd_q;
    rx_set     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        if (rx_prev_q & ~rx_s2_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_s2_q) begin
            rxd_d  = rx_shift_q;
            rx_set = 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // a flag set on the same edge as a read-clear survives
  assign tx_done_d  = tx_set | (tx_done_q & ~con_rd);
  assign rx_valid_d = rx_set | (rx_valid_q & ~con_rd);
  assign ie_d       = con_wr ? Write_data[1:0] : ie_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      rx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      rx_bit_q   <= '0;
      txd_q      <= '0;
      rxd_q      <= '0;
      rx_shift_q <= '0;
      ie_q       <= '0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      uart_tx_q  <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      rx_bit_q   <= rx_bit_d;
      txd_q      <= txd_d;
      rxd_q      <= rxd_d;
      rx_shift_q <= rx_shift_d;
      ie_q       <= ie_d;
      tx_done_q  <= tx_done_d;
      rx_valid_q <= rx_valid_d;
      uart_tx_q  <= uart_tx_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

  assign uart_tx = uart_tx_q;
  assign irq     = (ie_q[0] & tx_done_q) | (ie_q[1] & rx_valid_q);

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Directed bench for uart_mmio_periph: register map, TX frame,
// RX frames, glitch/framing/overrun cases and async reset.
module tb_uart_mmio_periph;

  localparam int CPB = 8;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] RXD  = BASE + 32'd4;
  localparam logic [31:0] CON  = BASE + 32'd8;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Mem_data;
  logic        hit;
  logic        uart_rx;
  logic        uart_tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_mmio_periph #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Mem_data  (Mem_data),
    .hit       (hit),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1 d = Mem_data;
    @(negedge clk);
    MemRead = 1'b0;
    Address = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input logic rd_mid_stop);
    logic [31:0] d;
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop;
    if (rd_mid_stop) begin
      tick(CPB - 2);
      rd(CON, d);
      chk("con_pre_set", d, 32'h02);
      tick(1);
    end else begin
      tick(CPB);
    end
    uart_rx = 1'b1;
  endtask

  task automatic idle_watch(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  frame;
    int          lows;

    reset      = 1'b0;
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    uart_rx    = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);

    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    rd(CON, d);
    chk("rst_con", d, 32'h0);
    Address = BASE + 32'd12;
    #1 chk("hit_unmapped", 32'(hit), 32'd0);
    chk("data_unmapped", Mem_data, 32'h0);
    Address = CON;
    #1 chk("hit_con", 32'(hit), 32'd1);
    Address = '0;
    tick(1);

    // TX frame of 0xA5, with a busy-time store of 0x55 that must be dropped
    wr(TXD, 32'hA5);
    chk("tx_idle_before_start", 32'(uart_tx), 32'd1);
    rd(CON, d);
    chk("con_busy", d, 32'h10);
    Address = TXD + 32'd1;
    #1 chk("hit_misalign", 32'(hit), 32'd0);
    chk("data_misalign", Mem_data, 32'h0);
    Address = '0;
    tick(3);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("tx_bit%0d", j), 32'(uart_tx), 32'(frame[j]));
      if (j == 4) begin
        rd(CON, d);
        chk("con_mid_frame", d, 32'h10);
        tick(7);
      end else if (j == 6) begin
        wr(TXD, 32'h55);
        tick(7);
      end else if (j < 9) begin
        tick(8);
      end
    end
    tick(4);
    rd(CON, d);
    chk("con_last_busy", d, 32'h10);
    chk("irq_tx_masked", 32'(irq), 32'd0);
    wr(CON, 32'h1);
    chk("irq_tx", 32'(irq), 32'd1);
    rd(CON, d);
    chk("con_done", d, 32'h09);
    chk("irq_tx_clr", 32'(irq), 32'd0);
    rd(CON, d);
    chk("con_cleared", d, 32'h01);
    rd(TXD, d);
    chk("txd_kept", d, 32'hA5);
    idle_watch(100, lows);
    chk("one_frame", 32'(lows), 32'd0);

    // RX of 0x3C with rx irq enabled
    wr(CON, 32'h1E);
    rd(CON, d);
    chk("con_wmask", d, 32'h02);
    send_byte(8'h3C, 1'b1, 1'b0);
    tick(2);
    rd(RXD, d);
    chk("rxd_3c", d, 32'h3C);
    chk("irq_rx", 32'(irq), 32'd1);
    rd(CON, d);
    chk("con_rx", d, 32'h06);
    chk("irq_rx_clr", 32'(irq), 32'd0);

    // glitch and framing error
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    rd(CON, d);
    chk("glitch_con", d, 32'h02);
    send_byte(8'h81, 1'b0, 1'b0);
    tick(4);
    rd(RXD, d);
    chk("framing_rxd", d, 32'h3C);
    rd(CON, d);
    chk("framing_con", d, 32'h02);

    // overrun, then completion coinciding with a CON read-clear
    send_byte(8'h11, 1'b1, 1'b0);
    tick(2);
    send_byte(8'h22, 1'b1, 1'b0);
    tick(2);
    rd(RXD, d);
    chk("overrun_rxd", d, 32'h22);
    rd(CON, d);
    chk("overrun_con", d, 32'h06);
    send_byte(8'h5A, 1'b1, 1'b1);
    rd(CON, d);
    chk("con_set_wins", d, 32'h06);
    rd(RXD, d);
    chk("rxd_5a", d, 32'h5A);

    // reset during a TX frame
    wr(TXD, 32'h00);
    tick(20);
    chk("tx_mid_low", 32'(uart_tx), 32'd0);
    reset = 1'b0;
    #1 chk("rst_async_tx", 32'(uart_tx), 32'd1);
    tick(2);
    reset = 1'b1;
    tick(1);
    rd(CON, d);
    chk("rst2_con", d, 32'h0);
    rd(TXD, d);
    chk("rst2_txd", d, 32'h0);
    rd(RXD, d);
    chk("rst2_rxd", d, 32'h0);
    idle_watch(100, lows);
    chk("rst2_idle", 32'(lows), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
